// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_stage
// Brief    : Instruction decode stage with register file, writeback bypass
//            and a single-entry valid/ready output register.
// Revision : 1.0
// ============================================================================
module id_stage #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int BYPASS_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] pc,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [5:0]        opcode,
    output logic [5:0]        funct,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [ADDR_W-1:0] rt,
    output logic [ADDR_W-1:0] rd,
    output logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] jump_dest,
    output logic [DATA_W-1:0] branch_dest
);

    localparam int              c_NUM_REGS = 1 << ADDR_W;
    localparam logic [DATA_W-1:0] c_PC_INC = DATA_W'(4);

    logic [DATA_W-1:0] r_regs [0:c_NUM_REGS-1];

    logic              r_valid;
    logic [5:0]        r_opcode;
    logic [5:0]        r_funct;
    logic [DATA_W-1:0] r_rsData;
    logic [DATA_W-1:0] r_rtData;
    logic [ADDR_W-1:0] r_rsIdx;
    logic [ADDR_W-1:0] r_rtIdx;
    logic [ADDR_W-1:0] r_rdIdx;
    logic [DATA_W-1:0] r_imm;
    logic [DATA_W-1:0] r_jumpDest;
    logic [DATA_W-1:0] r_branchDest;

    logic              w_wbWrite;
    logic              w_accept;
    logic [ADDR_W-1:0] w_rsIdx;
    logic [ADDR_W-1:0] w_rtIdx;
    logic [ADDR_W-1:0] w_rdIdx;
    logic [DATA_W-1:0] w_rsStored;
    logic [DATA_W-1:0] w_rtStored;
    logic [DATA_W-1:0] w_rsRead;
    logic [DATA_W-1:0] w_rtRead;
    logic [DATA_W-1:0] w_imm;
    logic [DATA_W-1:0] w_pcPlus4;
    logic [DATA_W-1:0] w_jumpDest;
    logic [DATA_W-1:0] w_branchDest;

    assign w_wbWrite = wb_en && (wb_addr != '0);
    assign in_ready  = !r_valid || out_ready;
    assign w_accept  = in_valid && in_ready && !flush;

    assign w_rsIdx = ADDR_W'(instr[25:21]);
    assign w_rtIdx = ADDR_W'(instr[20:16]);
    assign w_rdIdx = ADDR_W'(instr[15:11]);

    // Register 0 is forced to read zero regardless of array contents.
    assign w_rsStored = (w_rsIdx == '0) ? '0 : r_regs[w_rsIdx];
    assign w_rtStored = (w_rtIdx == '0) ? '0 : r_regs[w_rtIdx];

    generate
        if (BYPASS_EN != 0) begin : g_bypass
            assign w_rsRead = (w_wbWrite && (wb_addr == w_rsIdx)) ? wb_data : w_rsStored;
            assign w_rtRead = (w_wbWrite && (wb_addr == w_rtIdx)) ? wb_data : w_rtStored;
        end else begin : g_noBypass
            assign w_rsRead = w_rsStored;
            assign w_rtRead = w_rtStored;
        end
    endgenerate

    assign w_imm        = {{(DATA_W-16){instr[15]}}, instr[15:0]};
    assign w_pcPlus4    = pc + c_PC_INC;
    assign w_branchDest = w_pcPlus4 + (w_imm << 2);
    assign w_jumpDest   = {w_pcPlus4[DATA_W-1:28], instr[25:0], 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wbWrite) begin
            r_regs[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_opcode     <= '0;
            r_funct      <= '0;
            r_rsData     <= '0;
            r_rtData     <= '0;
            r_rsIdx      <= '0;
            r_rtIdx      <= '0;
            r_rdIdx      <= '0;
            r_imm        <= '0;
            r_jumpDest   <= '0;
            r_branchDest <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid      <= 1'b1;
            r_opcode     <= instr[31:26];
            r_funct      <= instr[5:0];
            r_rsData     <= w_rsRead;
            r_rtData     <= w_rtRead;
            r_rsIdx      <= w_rsIdx;
            r_rtIdx      <= w_rtIdx;
            r_rdIdx      <= w_rdIdx;
            r_imm        <= w_imm;
            r_jumpDest   <= w_jumpDest;
            r_branchDest <= w_branchDest;
        end else if (r_valid && !out_ready) begin
            // A stalled bundle must not go stale while writeback retires into its sources.
            if (w_wbWrite && (wb_addr == r_rsIdx)) begin
                r_rsData <= wb_data;
            end
            if (w_wbWrite && (wb_addr == r_rtIdx)) begin
                r_rtData <= wb_data;
            end
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid   = r_valid;
    assign opcode      = r_opcode;
    assign funct       = r_funct;
    assign rs_data     = r_rsData;
    assign rt_data     = r_rtData;
    assign rt          = r_rtIdx;
    assign rd          = r_rdIdx;
    assign imm         = r_imm;
    assign jump_dest   = r_jumpDest;
    assign branch_dest = r_branchDest;

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_stage
// Brief    : Directed plus randomized check of id_stage (bypass on and off)
//            against a behavioural model of the decode stage.
// Revision : 1.0
// ============================================================================
module tb_id_stage;

    typedef struct packed {
        logic        v;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] rsd;
        logic [31:0] rtd;
        logic [4:0]  rsi;
        logic [4:0]  rti;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [31:0] jd;
        logic [31:0] bd;
    } bundle_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] instr = '0;
    logic [31:0] pc = '0;
    logic        flush = 1'b0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        out_ready = 1'b0;

    logic        in_ready0, out_valid0, in_ready1, out_valid1;
    logic [5:0]  opcode0, funct0, opcode1, funct1;
    logic [31:0] rsData0, rtData0, imm0, jd0, bd0;
    logic [31:0] rsData1, rtData1, imm1, jd1, bd1;
    logic [4:0]  rt0, rd0, rt1, rd1;

    int checks = 0;
    int failures = 0;

    bundle_t     m [2];
    bundle_t     nextM [2];
    logic [31:0] mregs [2][32];

    always #5 clk = ~clk;

    id_stage #(.DATA_W(32), .ADDR_W(5), .BYPASS_EN(1)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .instr(instr), .pc(pc), .flush(flush), .wb_en(wb_en),
        .wb_addr(wb_addr), .wb_data(wb_data), .out_valid(out_valid0),
        .out_ready(out_ready), .opcode(opcode0), .funct(funct0),
        .rs_data(rsData0), .rt_data(rtData0), .rt(rt0), .rd(rd0),
        .imm(imm0), .jump_dest(jd0), .branch_dest(bd0)
    );

    id_stage #(.DATA_W(32), .ADDR_W(5), .BYPASS_EN(0)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .instr(instr), .pc(pc), .flush(flush), .wb_en(wb_en),
        .wb_addr(wb_addr), .wb_data(wb_data), .out_valid(out_valid1),
        .out_ready(out_ready), .opcode(opcode1), .funct(funct1),
        .rs_data(rsData1), .rt_data(rtData1), .rt(rt1), .rd(rd1),
        .imm(imm1), .jump_dest(jd1), .branch_dest(bd1)
    );

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mkR(int rs, int rt, int rd, int fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
    endfunction

    // Behavioural model: one call per clock edge, using the inputs driven before it.
    task automatic modelStep();
        for (int b = 0; b < 2; b++) begin
            bundle_t     n;
            logic [31:0] rsv, rtv, sext;
            int          rsi, rti;
            bit          wr, acc, byp;
            n    = m[b];
            byp  = (b == 0);
            rsi  = int'(instr[25:21]);
            rti  = int'(instr[20:16]);
            wr   = wb_en && (wb_addr != 0);
            rsv  = (byp && wr && int'(wb_addr) == rsi) ? wb_data : mregs[b][rsi];
            rtv  = (byp && wr && int'(wb_addr) == rti) ? wb_data : mregs[b][rti];
            acc  = in_valid && (!m[b].v || out_ready) && !flush;
            sext = 32'(signed'(instr[15:0]));
            if (rst) begin
                n = '0;
                for (int r = 0; r < 32; r++) mregs[b][r] = 32'h0;
            end else begin
                if (flush) begin
                    n.v = 1'b0;
                end else if (acc) begin
                    n.v   = 1'b1;
                    n.op  = instr[31:26];
                    n.fn  = instr[5:0];
                    n.rsd = rsv;
                    n.rtd = rtv;
                    n.rsi = instr[25:21];
                    n.rti = instr[20:16];
                    n.rd  = instr[15:11];
                    n.imm = sext;
                    n.bd  = pc + 32'd4 + sext * 32'd4;
                    n.jd  = ((pc + 32'd4) & 32'hF000_0000) | (32'(instr[25:0]) * 32'd4);
                end else if (m[b].v && !out_ready) begin
                    if (wr && wb_addr == m[b].rsi) n.rsd = wb_data;
                    if (wr && wb_addr == m[b].rti) n.rtd = wb_data;
                end else begin
                    n.v = 1'b0;
                end
                if (wr) mregs[b][wb_addr] = wb_data;
            end
            nextM[b] = n;
        end
    endtask

    task automatic chkDut(int b, bit allFields, logic v, logic ir, logic [5:0] op,
                          logic [5:0] fn, logic [31:0] rsd, logic [31:0] rtd,
                          logic [4:0] rtIdx, logic [4:0] rdIdx, logic [31:0] im,
                          logic [31:0] jd, logic [31:0] bd);
        string p;
        p = $sformatf("d%0d.", b);
        chk({p, "out_valid"}, 32'(v), 32'(m[b].v));
        chk({p, "in_ready"}, 32'(ir), 32'(!m[b].v || out_ready));
        if (m[b].v || allFields) begin
            chk({p, "opcode"}, 32'(op), 32'(m[b].op));
            chk({p, "funct"}, 32'(fn), 32'(m[b].fn));
            chk({p, "rs_data"}, rsd, m[b].rsd);
            chk({p, "rt_data"}, rtd, m[b].rtd);
            chk({p, "rt"}, 32'(rtIdx), 32'(m[b].rti));
            chk({p, "rd"}, 32'(rdIdx), 32'(m[b].rd));
            chk({p, "imm"}, im, m[b].imm);
            chk({p, "jump_dest"}, jd, m[b].jd);
            chk({p, "branch_dest"}, bd, m[b].bd);
        end
    endtask

    task automatic tick(bit allFields = 1'b0);
        modelStep();
        @(posedge clk);
        m = nextM;
        #1;
        chkDut(0, allFields, out_valid0, in_ready0, opcode0, funct0, rsData0, rtData0,
               rt0, rd0, imm0, jd0, bd0);
        chkDut(1, allFields, out_valid1, in_ready1, opcode1, funct1, rsData1, rtData1,
               rt1, rd1, imm1, jd1, bd1);
    endtask

    task automatic idle();
        in_valid = 1'b0; flush = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
    endtask

    initial begin
        logic [31:0] instrB;
        m[0] = '0; m[1] = '0;
        for (int r = 0; r < 32; r++) begin mregs[0][r] = '0; mregs[1][r] = '0; end

        // Reset, with an instruction presented that must be dropped
        rst = 1'b1; in_valid = 1'b1; instr = mkR(1, 2, 3, 4); out_ready = 1'b1;
        tick(1'b1);
        tick(1'b1);
        rst = 1'b0; idle();
        tick(1'b1);

        // Write r5, then read it
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234;
        tick();
        wb_en = 1'b0; in_valid = 1'b1; instr = mkR(5, 0, 3, 6'h20); pc = 32'h100;
        tick();
        chk("r5_read", rsData0, 32'h1234);
        chk("r0_read", rtData0, 32'h0);
        chk("r5_valid", 32'(out_valid0), 32'h1);

        // Same-cycle writeback vs read, bypass on and off
        in_valid = 1'b0; wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h11;
        tick();
        in_valid = 1'b1; instr = mkR(7, 0, 1, 0); wb_data = 32'hAA;
        tick();
        chk("bypass_on", rsData0, 32'hAA);
        chk("bypass_off", rsData1, 32'h11);

        // Immediate, branch and jump targets
        wb_en = 1'b0; instr = 32'h1000FFFF; pc = 32'h0040_0000;
        tick();
        chk("imm_neg", imm0, 32'hFFFF_FFFF);
        chk("branch_back", bd0, 32'h0040_0000);
        instr = 32'h0800_0010;
        tick();
        chk("jump_dest", jd0, 32'h0000_0040);

        // Stall with writeback into the held rt index
        instr = mkR(3, 9, 2, 6'h21);
        tick();
        instrB = mkR(9, 5, 4, 6'h2A);
        out_ready = 1'b0; instr = instrB;
        tick();
        chk("stall_in_ready", 32'(in_ready0), 32'h0);
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h5555;
        tick();
        chk("stall_rt_update", rtData0, 32'h5555);
        chk("stall_funct_hold", 32'(funct0), 32'h21);
        wb_en = 1'b0;
        tick();
        out_ready = 1'b1;
        tick();
        chk("after_stall_funct", 32'(funct0), 32'h2A);

        // Flush drops both the held and the incoming instruction
        flush = 1'b1; instr = mkR(1, 1, 1, 6'h3F);
        tick();
        chk("flush_valid", 32'(out_valid0), 32'h0);
        idle();
        tick();
        chk("flush_no_late", 32'(out_valid0), 32'h0);

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 9) == 0);
            instr     = $urandom();
            pc        = $urandom();
            wb_en     = $urandom_range(0, 1) == 1;
            wb_data   = $urandom();
            case ($urandom_range(0, 3))
                0: wb_addr = instr[25:21];
                1: wb_addr = instr[20:16];
                2: wb_addr = m[0].rti;
                default: wb_addr = 5'($urandom_range(0, 31));
            endcase
            tick();
        end

        // Fill every register, stall, then reset mid-stall
        idle();
        for (int r = 1; r < 32; r++) begin
            wb_en = 1'b1; wb_addr = 5'(r); wb_data = 32'hA000_0000 + 32'(r);
            tick();
        end
        wb_en = 1'b0; in_valid = 1'b1; instr = mkR(4, 6, 8, 6'h11);
        tick();
        out_ready = 1'b0;
        tick();
        rst = 1'b1;
        tick(1'b1);
        chk("rst_valid", 32'(out_valid0), 32'h0);
        chk("rst_rs_data", rsData0, 32'h0);
        rst = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
        for (int r = 0; r < 32; r++) begin
            instr = mkR(r, 31 - r, 0, 0);
            tick();
            chk("post_rst_read", rsData0 | rtData0 | rsData1 | rtData1, 32'h0);
        end
        idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 The block SHALL expose parameter DATA_W, default 32, meaning register/PC/data width; legal values >= 32.
REQ-002 The block SHALL expose parameter ADDR_W, default 5, meaning register address width; register count is 2^ADDR_W.
REQ-003 The block SHALL expose parameter BYPASS_EN, default 1, meaning same-cycle writeback-to-read forwarding enabled (1) or disabled (0).
REQ-004 The block SHALL use one clock and a synchronous active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-005 Ports SHALL be, in order after clk and rst:
- in_valid  in  1  fetch presents instruction
- in_ready  out  1  stage accepts instruction
- instr  in  32  instruction word
- pc  in  DATA_W  address of instr
- flush  in  1  discard held and incoming instruction
- wb_en  in  1  register write enable
- wb_addr  in  ADDR_W  write register index
- wb_data  in  DATA_W  write data
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute accepts bundle
- opcode  out  6  instr[31:26]
- funct  out  6  instr[5:0]
- rs_data  out  DATA_W  register[instr[25:21]]
- rt_data  out  DATA_W  register[instr[20:16]]
- rt  out  ADDR_W  instr[20:16] (zero-extended/truncated to ADDR_W)
- rd  out  ADDR_W  instr[15:11] (zero-extended/truncated to ADDR_W)
- imm  out  DATA_W  sign-extended instr[15:0]
- jump_dest  out  DATA_W  jump target
- branch_dest  out  DATA_W  branch target

Function
REQ-006 Register file SHALL hold 2^ADDR_W entries of DATA_W bits, written on rising clk when wb_en=1 and wb_addr!=0; register 0 SHALL always read 0.
REQ-007 Register file read SHALL be combinational on the incoming instr fields; result captured into output register at accept.
REQ-008 With BYPASS_EN=1, a read whose index equals wb_addr while wb_en=1 and wb_addr!=0 SHALL return wb_data that same cycle; with BYPASS_EN=0 it SHALL return the pre-write value.
REQ-009 in_ready SHALL equal (!out_valid || out_ready); an instruction is accepted when in_valid && in_ready && !flush.
REQ-010 Latency SHALL be one cycle: a bundle accepted at edge N is presented with out_valid=1 after edge N.
REQ-011 When out_valid=1 and out_ready=0, all outputs SHALL hold, except REQ-012.
REQ-012 While holding, if wb_en=1 and wb_addr!=0 matches held rs (resp. rt) index, held rs_data (resp. rt_data) SHALL update to wb_data at that edge (both if both match).
REQ-013 When out_ready=1 and no accept occurs, out_valid SHALL clear at the next edge; when accept and out_ready coincide, new bundle replaces old with out_valid staying 1.
REQ-014 flush=1 SHALL clear out_valid at the next edge and drop any in_valid instruction that cycle; flush has priority over accept and hold.
REQ-015 imm SHALL be instr[15] replicated to DATA_W-16 bits concatenated with instr[15:0].
REQ-016 branch_dest SHALL be (pc + 4 + (imm << 2)) modulo 2^DATA_W.
REQ-017 jump_dest SHALL be {(pc+4)[DATA_W-1:28], instr[25:0], 2'b00}.
REQ-018 Decode-only outputs (opcode, funct, rt, rd, imm, jump_dest, branch_dest) SHALL come from the output register, not live instr.

Reset
REQ-019 On rst=1 at a rising edge, out_valid, opcode, funct, rs_data, rt_data, rt, rd, imm, jump_dest, branch_dest SHALL be 0 and all registers SHALL clear to 0 in that cycle; in_ready SHALL be 1 after reset.
REQ-020 rst SHALL override flush, accept, hold and wb writes; an instruction presented during reset is dropped.

Verification
REQ-021 Write wb_addr=5, wb_data=0x1234 one cycle, then instr rs=5 rt=0 -> rs_data=0x1234, rt_data=0, out_valid=1 one cycle after accept.
REQ-022 BYPASS_EN=1: wb_en=1, wb_addr=7, wb_data=0xAA in same cycle as instr rs=7 accepted -> rs_data=0xAA; BYPASS_EN=0 same stimulus -> rs_data=old value.
REQ-023 instr=0x1000FFFF, pc=0x00400000 accepted -> imm=0xFFFFFFFF, branch_dest=0x00400000; instr=0x08000010 -> jump_dest=0x00000040.
REQ-024 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable; wb write to held rt index in cycle 2 -> rt_data updates; out_ready=1 -> next instruction appears next cycle.
REQ-025 flush=1 while out_valid=1 and in_valid=1 -> out_valid=0 next cycle, incoming instruction never appears.
REQ-026 Assert rst mid-stall with registers 1..31 nonzero -> out_valid=0, all outputs 0, subsequent reads of every register return 0.
